// File: rtl/pc_ctrl.sv
// Program-counter controller for the IF stage: prioritised redirect, single-step debug mode,
// halt back to the reset vector and a saturating count of PC updates since the last start.
module pc_ctrl #(
  parameter int unsigned            PC_SIZE      = 32,
  parameter logic [PC_SIZE-1:0]     RESET_VECTOR = '0,
  parameter int unsigned            PC_STEP      = 4,
  parameter int unsigned            COUNT_SIZE   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_halt,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic                  i_enable,
  input  logic                  i_not_load,
  input  logic                  i_exc_valid,
  input  logic [PC_SIZE-1:0]    i_exc_pc,
  input  logic                  i_jmp_valid,
  input  logic [PC_SIZE-1:0]    i_jmp_pc,
  output logic [PC_SIZE-1:0]    o_pc,
  output logic [PC_SIZE-1:0]    o_pc_seq,
  output logic [COUNT_SIZE-1:0] o_count,
  output logic                  o_running,
  output logic                  o_halted
);

  localparam logic [PC_SIZE-1:0]    StepW    = PC_SIZE'(PC_STEP);
  localparam logic [COUNT_SIZE-1:0] CountMax = '1;

  typedef enum logic [1:0] {StIdle, StRun, StStepWait, StHalted} state_e;

  state_e                r_state, w_state_next;
  logic [PC_SIZE-1:0]    r_pc, w_pc_next, w_target;
  logic [COUNT_SIZE-1:0] r_count, w_count_next;
  logic                  w_qualify;
  state_e                w_start_state;

  assign o_pc_seq      = r_pc + StepW;
  assign w_target      = i_exc_valid ? i_exc_pc : (i_jmp_valid ? i_jmp_pc : o_pc_seq);
  assign w_start_state = i_step_mode ? StStepWait : StRun;

  // A step pulse that lands on a stalled or disabled cycle is simply lost.
  assign w_qualify = i_enable && !i_not_load &&
                     ((r_state == StRun) || ((r_state == StStepWait) && i_step));

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_count_next = r_count;
    unique case (r_state)
      StIdle: begin
        if (i_halt) begin
          w_state_next = StHalted;
        end else if (i_start) begin
          w_state_next = w_start_state;
          w_count_next = '0;
        end
      end
      StRun, StStepWait: begin
        if (i_halt) begin
          w_state_next = StHalted;
          w_pc_next    = RESET_VECTOR;
        end else if (w_qualify) begin
          w_pc_next = w_target;
          if (r_count != CountMax) w_count_next = r_count + 1'b1;
        end
      end
      StHalted: begin
        w_pc_next = RESET_VECTOR;
        if (i_start && !i_halt) begin
          w_state_next = w_start_state;
          w_count_next = '0;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_pc    <= RESET_VECTOR;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_count <= w_count_next;
    end
  end

  assign o_pc      = r_pc;
  assign o_count   = r_count;
  assign o_running = (r_state == StRun) || (r_state == StStepWait);
  assign o_halted  = (r_state == StHalted);

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: directed test-plan sequence plus random traffic, checked
// against a behavioural model of the controller.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, halt, smode, step, en, nl, ev, jv;
  logic [31:0] epc, jpc;
  logic [31:0] pc, pc_seq;
  logic [3:0]  cnt;
  logic        running, halted;

  pc_ctrl #(
    .PC_SIZE     (32),
    .RESET_VECTOR(32'h0),
    .PC_STEP     (4),
    .COUNT_SIZE  (4)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_halt     (halt),
    .i_step_mode(smode),
    .i_step     (step),
    .i_enable   (en),
    .i_not_load (nl),
    .i_exc_valid(ev),
    .i_exc_pc   (epc),
    .i_jmp_valid(jv),
    .i_jmp_pc   (jpc),
    .o_pc       (pc),
    .o_pc_seq   (pc_seq),
    .o_count    (cnt),
    .o_running  (running),
    .o_halted   (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  cnt;
    bit          run;
    bit          hlt;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Behavioural model: "active" covers both running modes, m_stepm picks which one.
  logic [31:0] m_pc = 32'h0;
  int          m_cnt = 0;
  bit          m_active = 0, m_stepm = 0, m_halted = 0;

  task automatic model_update();
    if (rst) begin
      m_pc = 32'h0; m_cnt = 0; m_active = 0; m_halted = 0;
    end else if (m_active) begin
      if (halt) begin
        m_active = 0; m_halted = 1; m_pc = 32'h0;
      end else if (en && !nl && (!m_stepm || step)) begin
        m_pc  = ev ? epc : (jv ? jpc : m_pc + 32'd4);
        m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      end
    end else if (m_halted) begin
      if (start && !halt) begin
        m_active = 1; m_halted = 0; m_stepm = smode; m_cnt = 0;
      end
    end else begin
      if (halt) m_halted = 1;
      else if (start) begin
        m_active = 1; m_stepm = smode; m_cnt = 0;
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    model_update();
    e.pc = m_pc; e.cnt = m_cnt[3:0]; e.run = m_active; e.hlt = m_halted;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        n_vec++;
        if (pc !== e.pc || cnt !== e.cnt || running !== e.run || halted !== e.hlt ||
            pc_seq !== e.pc + 32'd4) begin
          n_bad++;
          $display("FAIL scoreboard @%0t: pc=%h cnt=%0d run=%b hlt=%b seq=%h, expected pc=%h cnt=%0d run=%b hlt=%b seq=%h",
                   $time, pc, cnt, running, halted, pc_seq, e.pc, e.cnt, e.run, e.hlt,
                   e.pc + 32'd4);
        end
      end
    end
  end

  initial begin : stim
    rst = 1; start = 0; halt = 0; smode = 0; step = 0; en = 0; nl = 0;
    ev = 0; jv = 0; epc = '0; jpc = '0;
    tick(); tick();
    rst = 0;
    check("reset_pc", pc, 32'h0);
    check("reset_cnt", {28'h0, cnt}, 32'd0);
    check("reset_flags", {30'h0, running, halted}, 32'd0);

    // Free run
    en = 1; start = 1; tick(); start = 0;
    repeat (10) tick();
    check("free_pc", pc, 32'd40);
    check("free_cnt", {28'h0, cnt}, 32'd10);
    check("free_running", {31'h0, running}, 32'd1);

    // Stall and disable
    nl = 1; repeat (5) tick(); nl = 0;
    en = 0; repeat (5) tick(); en = 1;
    check("stall_pc", pc, 32'd40);
    check("stall_cnt", {28'h0, cnt}, 32'd10);
    repeat (5) tick();
    check("release_pc", pc, 32'd60);

    // Redirect priority
    ev = 1; epc = 32'h80; jv = 1; jpc = 32'h100; tick(); ev = 0;
    check("exc_over_jmp", pc, 32'h80);
    tick(); jv = 0;
    check("jmp_pc", pc, 32'h100);
    tick();
    check("after_jmp_seq", pc, 32'h104);

    // Halt / restart
    halt = 1; tick();
    check("halt_pc", pc, 32'h0);
    check("halt_flag", {31'h0, halted}, 32'd1);
    start = 1; tick();
    check("start_halt_stays", {31'h0, halted}, 32'd1);
    halt = 0; tick(); start = 0;
    check("restart_cnt", {28'h0, cnt}, 32'd0);
    check("restart_running", {31'h0, running}, 32'd1);

    // Step mode
    halt = 1; tick(); halt = 0;
    smode = 1; start = 1; tick(); start = 0; smode = 0;
    repeat (8) tick();
    check("step_idle_pc", pc, 32'h0);
    repeat (3) begin
      step = 1; tick(); step = 0; tick();
    end
    check("step3_pc", pc, 32'd12);
    nl = 1; step = 1; tick(); step = 0; nl = 0; tick();
    check("step_stalled_pc", pc, 32'd12);

    // Boundaries
    halt = 1; tick(); halt = 0;
    start = 1; tick(); start = 0;
    jv = 1; jpc = 32'hFFFF_FFFC; tick(); jv = 0;
    check("pc_seq_wrap", pc_seq, 32'h0);
    tick();
    check("pc_wrap", pc, 32'h0);
    repeat (20) tick();
    check("cnt_saturate", {28'h0, cnt}, 32'd15);
    rst = 1; start = 1; tick(); rst = 0; start = 0;
    check("midrun_reset_pc", pc, 32'h0);
    check("midrun_reset_cnt", {28'h0, cnt}, 32'd0);
    check("midrun_reset_flags", {30'h0, running, halted}, 32'd0);

    // Random traffic
    repeat (600) begin
      rst   = ($urandom_range(0, 99) < 2);
      halt  = ($urandom_range(0, 99) < 5);
      start = ($urandom_range(0, 99) < 15);
      smode = $urandom_range(0, 1);
      step  = $urandom_range(0, 1);
      en    = ($urandom_range(0, 9) < 8);
      nl    = ($urandom_range(0, 9) < 2);
      ev    = ($urandom_range(0, 9) < 1);
      jv    = ($urandom_range(0, 9) < 2);
      epc   = $urandom & 32'hFFFF_FFFC;
      jpc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      tick();
    end
    rst = 0; halt = 0; start = 0; ev = 0; jv = 0;

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
